// File: rtl/accum_bank_if.sv
// accum_bank_if: add / clear / read bundle for the accumulator bank.
//   master : producer side (drives add, clear and read requests)
//   slave  : accumulator bank side (drives in_ready and the read response)
// Signals:
//   in_valid/in_ready/in_chan/in_data  add request handshake
//   clr_valid/clr_chan                 clear request (no ready)
//   rd_req/rd_chan                     read request
//   rd_valid/rd_data/rd_ovf            read response, one cycle after rd_req
//   ovf_flags                          sticky per-channel overflow flags
interface accum_bank_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NCHAN = 4
);
  localparam int unsigned CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [CHW-1:0]   in_chan;
  logic [WIDTH-1:0] in_data;
  logic             clr_valid;
  logic [CHW-1:0]   clr_chan;
  logic             rd_req;
  logic [CHW-1:0]   rd_chan;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ovf;
  logic [NCHAN-1:0] ovf_flags;

  modport master (
    output in_valid, in_chan, in_data, clr_valid, clr_chan, rd_req, rd_chan,
    input  in_ready, rd_valid, rd_data, rd_ovf, ovf_flags
  );

  modport slave (
    input  in_valid, in_chan, in_data, clr_valid, clr_chan, rd_req, rd_chan,
    output in_ready, rd_valid, rd_data, rd_ovf, ovf_flags
  );
endinterface

// File: rtl/accum_bank.sv
// accum_bank: NCHAN independent WIDTH-bit accumulators, acc <= acc + data + INCR.
// Ports:
//   clk  clock, all logic on posedge
//   rst  synchronous reset, active high
//   bus  accum_bank_if.slave: add port (valid/ready), clear port, read port
//        with one-cycle latency, sticky overflow flags per channel.
// Arithmetic wraps (SATURATE=0) or clamps at all-ones (SATURATE=1); a carry
// out of the WIDTH-bit sum sets the channel's sticky overflow flag either way.
// Out-of-range channel indices: adds are accepted and dropped, clears are
// ignored, reads return zero.
module accum_bank #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NCHAN    = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned INCR     = 1
) (
  input logic         clk,
  input logic         rst,
  accum_bank_if.slave bus
);

  localparam int unsigned CHW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int unsigned NIDX = 1 << CHW;
  localparam logic [WIDTH:0] INCR_EXT = (WIDTH + 1)'(INCR);

  // Elaboration-time parameter sanity
  if (WIDTH < 2) begin : g_bad_width
    $error("accum_bank: WIDTH must be >= 2");
  end
  if (INCR > 1) begin : g_bad_incr
    $error("accum_bank: INCR must be 0 or 1");
  end
  if (NCHAN < 1) begin : g_bad_nchan
    $error("accum_bank: NCHAN must be >= 1");
  end

  logic [WIDTH-1:0] acc_q [NCHAN];
  logic [WIDTH-1:0] acc_d [NCHAN];
  logic [NCHAN-1:0] ovf_q;
  logic [NCHAN-1:0] ovf_d;

  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_ovf_q;

  logic [NIDX-1:0]  chan_ok;
  logic             in_ready_c;
  logic             add_fire_c;
  logic [WIDTH-1:0] add_acc_c;
  logic [WIDTH:0]   sum_c;
  logic             carry_c;
  logic [WIDTH-1:0] add_res_c;
  logic [WIDTH-1:0] rd_acc_c;
  logic             rd_ovf_c;

  // chan_ok[i]: index i addresses a real channel (matters when NCHAN is not a power of two)
  always_comb begin
    chan_ok = '0;
    for (int unsigned i = 0; i < NIDX; i++) begin
      chan_ok[i] = (i < NCHAN);
    end
  end

  // Add may not proceed while a clear targets the same channel; the clear wins
  // and the producer holds the add.
  always_comb begin
    in_ready_c = !rst && !(bus.clr_valid && (bus.clr_chan == bus.in_chan));
    add_fire_c = bus.in_valid && in_ready_c && chan_ok[bus.in_chan];
  end

  // Current value of the add target
  always_comb begin
    add_acc_c = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (bus.in_chan == CHW'(i)) begin
        add_acc_c = acc_q[i];
      end
    end
  end

  // WIDTH+1-bit sum; the top bit is the carry that drives overflow/saturation
  always_comb begin
    sum_c     = {1'b0, add_acc_c} + {1'b0, bus.in_data} + INCR_EXT;
    carry_c   = sum_c[WIDTH];
    add_res_c = (SATURATE && carry_c) ? '1 : sum_c[WIDTH-1:0];
  end

  // Next-state for every channel: clear has priority over add
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (bus.clr_valid && (bus.clr_chan == CHW'(i))) begin
        acc_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (add_fire_c && (bus.in_chan == CHW'(i))) begin
        acc_d[i] = add_res_c;
        if (carry_c) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Read mux on pre-update state; out-of-range channels read as zero
  always_comb begin
    rd_acc_c = '0;
    rd_ovf_c = 1'b0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (bus.rd_chan == CHW'(i)) begin
        rd_acc_c = acc_q[i];
        rd_ovf_c = ovf_q[i];
      end
    end
  end

  // Accumulator and flag state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // Read response register; data/ovf hold when no read is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        rd_data_q <= rd_acc_c;
        rd_ovf_q  <= rd_ovf_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_ovf    = rd_ovf_q;
  assign bus.ovf_flags = ovf_q;

endmodule

// File: tb/tb_accum_bank.sv
// tb_accum_bank: three accumulator banks driven by one shared stimulus stream
//   u_a: WIDTH=64, NCHAN=4, wrap
//   u_b: WIDTH=8,  NCHAN=4, wrap
//   u_c: WIDTH=8,  NCHAN=3, saturate (channel 3 is out of range)
// A per-instance arithmetic model predicts in_ready, read responses and flags.
module tb_accum_bank;

  logic clk;
  logic rst;
  logic        in_valid;
  logic [1:0]  in_chan;
  logic [63:0] in_data;
  logic        clr_valid;
  logic [1:0]  clr_chan;
  logic        rd_req;
  logic [1:0]  rd_chan;

  accum_bank_if #(.WIDTH(64), .NCHAN(4)) bus_a ();
  accum_bank_if #(.WIDTH(8),  .NCHAN(4)) bus_b ();
  accum_bank_if #(.WIDTH(8),  .NCHAN(3)) bus_c ();

  accum_bank #(.WIDTH(64), .NCHAN(4), .SATURATE(1'b0), .INCR(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  accum_bank #(.WIDTH(8),  .NCHAN(4), .SATURATE(1'b0), .INCR(1)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  accum_bank #(.WIDTH(8),  .NCHAN(3), .SATURATE(1'b1), .INCR(1)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  assign bus_a.in_valid = in_valid;   assign bus_b.in_valid = in_valid;   assign bus_c.in_valid = in_valid;
  assign bus_a.in_chan  = in_chan;    assign bus_b.in_chan  = in_chan;    assign bus_c.in_chan  = in_chan;
  assign bus_a.in_data  = in_data;    assign bus_b.in_data  = in_data[7:0]; assign bus_c.in_data = in_data[7:0];
  assign bus_a.clr_valid = clr_valid; assign bus_b.clr_valid = clr_valid; assign bus_c.clr_valid = clr_valid;
  assign bus_a.clr_chan  = clr_chan;  assign bus_b.clr_chan  = clr_chan;  assign bus_c.clr_chan  = clr_chan;
  assign bus_a.rd_req   = rd_req;     assign bus_b.rd_req   = rd_req;     assign bus_c.rd_req   = rd_req;
  assign bus_a.rd_chan  = rd_chan;    assign bus_b.rd_chan  = rd_chan;    assign bus_c.rd_chan  = rd_chan;

  logic        rdy_o  [3];
  logic        rdv_o  [3];
  logic [63:0] rdd_o  [3];
  logic        rdo_o  [3];
  logic [3:0]  ovf_o  [3];

  assign rdy_o[0] = bus_a.in_ready;  assign rdy_o[1] = bus_b.in_ready;  assign rdy_o[2] = bus_c.in_ready;
  assign rdv_o[0] = bus_a.rd_valid;  assign rdv_o[1] = bus_b.rd_valid;  assign rdv_o[2] = bus_c.rd_valid;
  assign rdd_o[0] = bus_a.rd_data;   assign rdd_o[1] = 64'(bus_b.rd_data); assign rdd_o[2] = 64'(bus_c.rd_data);
  assign rdo_o[0] = bus_a.rd_ovf;    assign rdo_o[1] = bus_b.rd_ovf;    assign rdo_o[2] = bus_c.rd_ovf;
  assign ovf_o[0] = bus_a.ovf_flags; assign ovf_o[1] = bus_b.ovf_flags; assign ovf_o[2] = 4'(bus_c.ovf_flags);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state
  logic [63:0] m_acc [3][4];
  bit          m_ovf [3][4];
  bit          e_rdv [3];
  logic [63:0] e_rdd [3];
  bit          e_rdo [3];

  function automatic int cfg_w(input int k);
    return (k == 0) ? 64 : 8;
  endfunction

  function automatic int cfg_n(input int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic bit cfg_s(input int k);
    return (k == 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // acc + data + 1 against the channel's range; carry out flags, then wrap or clamp
  function automatic void model_add(input int k, input int c, input logic [63:0] d);
    logic [64:0] mx;
    logic [64:0] s;
    mx = (65'd1 << cfg_w(k)) - 65'd1;
    s  = {1'b0, m_acc[k][c]} + ({1'b0, d} & mx) + 65'd1;
    if (s > mx) begin
      m_ovf[k][c] = 1'b1;
      m_acc[k][c] = cfg_s(k) ? mx[63:0] : 64'(s - mx - 65'd1);
    end else begin
      m_acc[k][c] = s[63:0];
    end
  endfunction

  // One clock of stimulus; predicts and checks all three instances
  task automatic cycle(input bit r, input bit iv, input logic [1:0] ic, input logic [63:0] id,
                       input bit cv, input logic [1:0] cc, input bit rq, input logic [1:0] rc);
    bit ready_exp;
    logic [3:0] ev;
    @(negedge clk);
    rst = r; in_valid = iv; in_chan = ic; in_data = id;
    clr_valid = cv; clr_chan = cc; rd_req = rq; rd_chan = rc;
    #1;
    ready_exp = !r && !(cv && (cc == ic));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("in_ready[%0d]", k), 64'(rdy_o[k]), 64'(ready_exp));
      if (r) begin
        for (int c = 0; c < 4; c++) begin
          m_acc[k][c] = '0;
          m_ovf[k][c] = 1'b0;
        end
        e_rdv[k] = 1'b0;
        e_rdd[k] = '0;
        e_rdo[k] = 1'b0;
      end else begin
        e_rdv[k] = rq;
        if (rq) begin
          e_rdd[k] = (int'(rc) < cfg_n(k)) ? m_acc[k][rc] : 64'd0;
          e_rdo[k] = (int'(rc) < cfg_n(k)) ? m_ovf[k][rc] : 1'b0;
        end
        if (cv && int'(cc) < cfg_n(k)) begin
          m_acc[k][cc] = '0;
          m_ovf[k][cc] = 1'b0;
        end
        if (iv && ready_exp && int'(ic) < cfg_n(k)) begin
          model_add(k, int'(ic), id);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      ev = '0;
      for (int c = 0; c < cfg_n(k); c++) ev[c] = m_ovf[k][c];
      check($sformatf("rd_valid[%0d]", k), 64'(rdv_o[k]), 64'(e_rdv[k]));
      check($sformatf("rd_data[%0d]", k), rdd_o[k], e_rdd[k]);
      check($sformatf("rd_ovf[%0d]", k), 64'(rdo_o[k]), 64'(e_rdo[k]));
      check($sformatf("ovf_flags[%0d]", k), 64'(ovf_o[k]), 64'(ev));
    end
  endtask

  initial begin
    logic [63:0] d;
    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0;
    clr_valid = 1'b0; clr_chan = '0; rd_req = 1'b0; rd_chan = '0;

    // Reset
    cycle(1, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 1, 0, 5, 0, 0, 0, 0);
    check("rst_rd_valid", 64'(rdv_o[0]), 64'd0);

    // Three adds of 5 on ch0, then read: 3*(5+1)
    repeat (3) cycle(0, 1, 0, 5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("t1_rd_valid", 64'(rdv_o[0]), 64'd1);
    check("t1_rd_data", rdd_o[0], 64'd18);

    // Wrap on the 8-bit bank: 254+1=255, then 255+0+1 wraps to 0
    cycle(0, 1, 1, 254, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    check("t2_rd_data_b", rdd_o[1], 64'd0);
    check("t2_ovf_b", 64'(ovf_o[1]), 64'h2);

    // Saturation on ch2: 201, then 302 clamps to 255, adding 0 stays 255
    cycle(0, 1, 2, 200, 0, 0, 0, 0);
    cycle(0, 1, 2, 100, 0, 0, 1, 2);
    check("t3_rd_before_c", rdd_o[2], 64'd201);
    cycle(0, 0, 0, 0, 0, 0, 1, 2);
    check("t3_rd_sat_c", rdd_o[2], 64'd255);
    check("t3_flag_c", 64'(ovf_o[2][2]), 64'd1);
    cycle(0, 1, 2, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 2);
    check("t3_rd_hold_c", rdd_o[2], 64'd255);

    // Clear vs add on the same channel: clear wins, add refused
    cycle(0, 1, 3, 4, 0, 0, 0, 0);
    cycle(0, 1, 3, 4, 1, 3, 0, 0);
    check("t4_ready_same", 64'(rdy_o[0]), 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, 3);
    check("t4_rd_ch3", rdd_o[0], 64'd0);
    // Different channels: both act (a ch1 = 256, +2+1)
    cycle(0, 1, 1, 2, 1, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    check("t4_rd_ch1", rdd_o[0], 64'd259);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("t4_rd_ch0", rdd_o[0], 64'd0);

    // Read sees pre-update state
    cycle(0, 1, 0, 9, 0, 0, 0, 0);
    cycle(0, 1, 0, 7, 0, 0, 1, 0);
    check("t5_rd_pre", rdd_o[0], 64'd10);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("t5_rd_post", rdd_o[0], 64'd18);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_rd_idle", 64'(rdv_o[0]), 64'd0);
    check("t5_rd_hold", rdd_o[0], 64'd18);

    // Reset with a read in flight drops it
    cycle(0, 1, 0, 3, 0, 0, 1, 0);
    cycle(1, 1, 0, 3, 0, 0, 1, 0);
    check("t6_rd_valid", 64'(rdv_o[0]), 64'd0);
    check("t6_ovf_c", 64'(ovf_o[2]), 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    check("t6_rd_data", rdd_o[1], 64'd0);

    // Randomized traffic, biased toward overflow-prone data
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: d = {$urandom, $urandom};
        1: d = 64'hff;
        2: d = 64'($urandom_range(0, 20));
        default: d = '1;
      endcase
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), 2'($urandom), d,
            ($urandom_range(0, 5) == 0), 2'($urandom), 1'($urandom), 2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
